crc16_arb: RTL and testbench
============================

Name: crc16_arb

Overview:
- Shares one nibble-serial CRC16 engine (polynomial 0x1021, MSB-first) between N_REQ word-stream requesters.
- Round-robin arbitration happens per packet. A grant stays locked to one requester until its word marked last has been processed and its result accepted.
- Per-requester init and final-XOR values are inputs, driven from a config register bank elsewhere in the CRC subsystem.
- The block sits between DMA or peripheral stream sources and the CRC result sink.

Parameters:
- N_REQ, 4, number of requesters (2..8).
- ID_W, $clog2(N_REQ), width of requester index.

Ports:
- clk_i  in  1  clock.
- rst_i  in  1  asynchronous, active-high reset.
- en_i  in  1  arbitration enable, sampled only in IDLE.
- req_valid_i  in  N_REQ  per-requester word valid.
- req_ready_o  out  N_REQ  per-requester word accept.
- req_data_i  in  N_REQ*16  packed words; requester k at [16k+15:16k].
- req_last_i  in  N_REQ  word is last of packet.
- init_i  in  N_REQ*16  per-requester CRC init value.
- xorv_i  in  N_REQ*16  per-requester final XOR value.
- resp_valid_o  out  1  result valid.
- resp_ready_i  in  1  result accept.
- resp_id_o  out  ID_W  requester that owns the result.
- resp_crc_o  out  16  final CRC.
- busy_o  out  1  FSM not in IDLE.

Behaviour:
- Reset (asynchronous, any state): FSM goes to IDLE. All outputs are 0. Round-robin pointer rr=0. CRC register, data latch and grant register are cleared. Any packet in flight is discarded with no response.
- FSM states: IDLE, ACCEPT, SHIFT1, SHIFT2, SHIFT3, SHIFT4, RESP.
- IDLE:
  - If en_i and any req_valid_i: pick the first set valid scanning rr, rr+1, ... (mod N_REQ).
  - Latch gnt. Load crc <= init_i[gnt]. Next state ACCEPT.
  - If en_i=0, stay in IDLE regardless of valids.
- ACCEPT:
  - req_ready_o[gnt]=1; all other ready bits are 0.
  - On req_valid_i[gnt]: latch word and last, go to SHIFT1. Otherwise hold.
  - Valids from other requesters are ignored.
- SHIFT1..SHIFT4:
  - One nibble per cycle, in the order word[15:12], [11:8], [7:4], [3:0].
  - Each cycle: crc <= crc16_step(crc, nibble), i.e. 4 MSB-first bit steps, each step: fb=crc[15]^d; crc=(crc<<1) ^ (fb?0x1021:0).
  - After SHIFT4: go to RESP if last, else ACCEPT.
- RESP:
  - resp_valid_o=1, resp_id_o=gnt, resp_crc_o = crc ^ xorv_i[gnt], combinational from registers.
  - Outputs are held stable until resp_ready_i.
  - On handshake: rr <= (gnt+1) mod N_REQ, then IDLE.
- Throughput: 5 cycles per word minimum (ACCEPT plus 4 SHIFT), plus 1 IDLE cycle and ≥1 RESP cycle per packet.
- Minimum single-word packet latency: valid to resp_valid_o is 6 cycles.
- en_i deasserted mid-packet has no effect; the packet completes normally.
- init_i and xorv_i are sampled at grant (init) and in RESP (xorv). Software must not change them while the owning requester is granted.
- busy_o = (state != IDLE).
- A requester that drops valid mid-packet stalls the engine in ACCEPT. No timeout exists.

Optional Feature:
- Macro: CRC16_ARB_REFLECT_EN.
- When defined:
  - Adds input reflect_i [N_REQ].
  - If reflect_i[gnt]=1: the latched word is bit-reversed (bit i -> 15-i) before nibble slicing, and the final CRC is bit-reversed before the XOR with xorv.
  - reflect_i[gnt] is sampled at grant.
- When undefined: the port is absent and no reversal is applied.

Test Plan:
- Single word, requester 0, init=0x0000, xorv=0x0000, data=0x0001, last=1 -> resp_crc_o=0x1021, resp_id_o=0, resp_valid_o rises 6 cycles after valid.
- Same word as above with xorv=0xFFFF -> resp_crc_o=0xEFDE. With data=0x0002, xorv=0 -> resp_crc_o=0x2042.
- Two-word packet 0x0000 then 0x0001 (last), init=0 -> resp_crc_o=0x1021; req_ready_o[0] pulses exactly twice; no other ready bit is ever set.
- All 4 requesters valid with 1-word packets, rr=0 -> resp_id_o order 0,1,2,3,0; resp_ready_i held low 3 cycles in RESP -> outputs stable, no new grant.
- Requester 2 mid-packet (in SHIFT2) while requester 1 asserts valid; then en_i=0 -> packet 2 completes and responds; requester 1 is not granted until en_i=1.
- rst_i asserted during SHIFT3 -> next cycle busy_o=0, resp_valid_o=0, req_ready_o=0; after release, requester 0 is granted first.

Source files
------------

// File: rtl/crc16_arb.sv
// Round-robin arbiter sharing one nibble-serial CRC16 (poly 0x1021, MSB-first) engine
// between N_REQ word-stream requesters. Optional word/result reflection: CRC16_ARB_REFLECT_EN.
module crc16_arb #(
  parameter int N_REQ = 4,
  parameter int ID_W  = $clog2(N_REQ)
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  en_i,
  input  logic [N_REQ-1:0]      req_valid_i,
  output logic [N_REQ-1:0]      req_ready_o,
  input  logic [N_REQ*16-1:0]   req_data_i,
  input  logic [N_REQ-1:0]      req_last_i,
  input  logic [N_REQ*16-1:0]   init_i,
  input  logic [N_REQ*16-1:0]   xorv_i,
`ifdef CRC16_ARB_REFLECT_EN
  input  logic [N_REQ-1:0]      reflect_i,
`endif
  output logic                  resp_valid_o,
  input  logic                  resp_ready_i,
  output logic [ID_W-1:0]       resp_id_o,
  output logic [15:0]           resp_crc_o,
  output logic                  busy_o
);

  typedef enum logic [2:0] {
    IDLE, ACCEPT, SHIFT1, SHIFT2, SHIFT3, SHIFT4, RESP
  } state_t;

  state_t          state, state_nx;
  logic [ID_W-1:0] gnt, rr, pick;
  logic            found;
  logic [ID_W:0]   cand;
  logic [15:0]     crc, word;
  logic            last;
  logic            refl;
  logic [15:0]     data_sel, init_sel, xorv_sel, crc_fin;
  logic [3:0]      nib;

  function automatic logic [15:0] crc16_step(input logic [15:0] c, input logic [3:0] n);
    logic [15:0] r;
    r = c;
    for (int unsigned i = 0; i < 4; i++) begin
      if (r[15] ^ n[3-i]) r = (r << 1) ^ 16'h1021;
      else                r = r << 1;
    end
    return r;
  endfunction

  function automatic logic [15:0] rev16(input logic [15:0] v);
    logic [15:0] r;
    r = '0;
    for (int unsigned i = 0; i < 16; i++) r[i] = v[15-i];
    return r;
  endfunction

  assign data_sel = req_data_i[{gnt, 4'b0000} +: 16];
  assign init_sel = init_i[{pick, 4'b0000} +: 16];
  assign xorv_sel = xorv_i[{gnt, 4'b0000} +: 16];
  assign crc_fin  = refl ? rev16(crc) : crc;
  assign busy_o   = (state != IDLE);

  // Scan rr, rr+1, ... with explicit wrap so non-power-of-two N_REQ works.
  always_comb begin
    found = 1'b0;
    pick  = '0;
    cand  = '0;
    for (int unsigned i = 0; i < N_REQ; i++) begin
      cand = {1'b0, rr} + (ID_W+1)'(i);
      if (cand >= (ID_W+1)'(N_REQ)) cand = cand - (ID_W+1)'(N_REQ);
      if (!found && req_valid_i[cand[ID_W-1:0]]) begin
        found = 1'b1;
        pick  = cand[ID_W-1:0];
      end
    end
  end

  always_comb begin
    case (state)
      SHIFT1:  nib = word[15:12];
      SHIFT2:  nib = word[11:8];
      SHIFT3:  nib = word[7:4];
      default: nib = word[3:0];
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) state <= IDLE;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx     = state;
    req_ready_o  = '0;
    resp_valid_o = 1'b0;
    resp_id_o    = '0;
    resp_crc_o   = '0;
    case (state)
      IDLE:   if (en_i && found) state_nx = ACCEPT;
      ACCEPT: begin
        req_ready_o[gnt] = 1'b1;
        if (req_valid_i[gnt]) state_nx = SHIFT1;
      end
      SHIFT1: state_nx = SHIFT2;
      SHIFT2: state_nx = SHIFT3;
      SHIFT3: state_nx = SHIFT4;
      SHIFT4: state_nx = last ? RESP : ACCEPT;
      RESP: begin
        resp_valid_o = 1'b1;
        resp_id_o    = gnt;
        resp_crc_o   = crc_fin ^ xorv_sel;
        if (resp_ready_i) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

`ifdef CRC16_ARB_REFLECT_EN
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i)                                   refl <= 1'b0;
    else if (state == IDLE && en_i && found)     refl <= reflect_i[pick];
  end
`else
  assign refl = 1'b0;
`endif

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      gnt  <= '0;
      rr   <= '0;
      crc  <= '0;
      word <= '0;
      last <= 1'b0;
    end else begin
      case (state)
        IDLE: if (en_i && found) begin
          gnt <= pick;
          crc <= init_sel;
        end
        ACCEPT: if (req_valid_i[gnt]) begin
          word <= refl ? rev16(data_sel) : data_sel;
          last <= req_last_i[gnt];
        end
        SHIFT1, SHIFT2, SHIFT3, SHIFT4: crc <= crc16_step(crc, nib);
        RESP: if (resp_ready_i)
          rr <= (gnt == ID_W'(N_REQ-1)) ? '0 : gnt + 1'b1;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_crc16_arb.sv
// Self-checking bench for crc16_arb: per-scenario tasks compared against a
// bit-serial CRC and queue-based round-robin reference model.
module tb_crc16_arb;
  localparam int N = 4;

  logic            clk = 1'b0;
  logic            rst, en;
  logic [N-1:0]    valid, ready, last;
  logic [N*16-1:0] data, init_bus, xorv_bus;
  logic            resp_valid, resp_ready, busy;
  logic [1:0]      resp_id;
  logic [15:0]     resp_crc;
`ifdef CRC16_ARB_REFLECT_EN
  logic [N-1:0]    reflect;
  assign reflect = '0;
`endif

  logic [15:0] init_v [N];
  logic [15:0] xorv_v [N];
  for (genvar g = 0; g < N; g++) begin : g_cfg
    assign init_bus[16*g +: 16] = init_v[g];
    assign xorv_bus[16*g +: 16] = xorv_v[g];
  end

  always #5 clk = ~clk;

  crc16_arb #(.N_REQ(N)) dut (
    .clk_i(clk), .rst_i(rst), .en_i(en),
    .req_valid_i(valid), .req_ready_o(ready), .req_data_i(data), .req_last_i(last),
    .init_i(init_bus), .xorv_i(xorv_bus),
`ifdef CRC16_ARB_REFLECT_EN
    .reflect_i(reflect),
`endif
    .resp_valid_o(resp_valid), .resp_ready_i(resp_ready),
    .resp_id_o(resp_id), .resp_crc_o(resp_crc), .busy_o(busy)
  );

  typedef struct { int id; logic [15:0] crc; } resp_t;

  logic [16:0] wq [N][$];
  logic [15:0] mw [N][$];
  int          mlen [N][$];
  int          cur_len [N];
  int          rr_m;
  resp_t       rq [$];
  logic [N-1:0] hs;
  logic        obs_valid, obs_busy;
  logic [N-1:0] obs_ready;
  logic [1:0]  obs_id;
  logic [15:0] obs_crc;
  int          rdy_cnt [N];
  bit          rand_ready;
  int          vectors = 0, miscompares = 0;

  function automatic logic [15:0] ref_crc(input logic [15:0] c, input logic [15:0] w);
    logic [15:0] r;
    logic fb;
    r = c;
    for (int b = 15; b >= 0; b--) begin
      fb = r[15] ^ w[b];
      r  = {r[14:0], 1'b0};
      if (fb) r = r ^ 16'h1021;
    end
    return r;
  endfunction

  task automatic drive();
    logic [16:0] e;
    for (int k = 0; k < N; k++) begin
      if (wq[k].size() > 0) begin
        e = wq[k][0];
        valid[k] = 1'b1; data[16*k +: 16] = e[15:0]; last[k] = e[16];
      end else begin
        valid[k] = 1'b0; data[16*k +: 16] = '0; last[k] = 1'b0;
      end
    end
  endtask

  task automatic step();
    if (resp_valid && resp_ready) rq.push_back('{id: int'(resp_id), crc: resp_crc});
    hs = valid & ready;
    @(posedge clk);
    #1;
    for (int k = 0; k < N; k++)
      if (hs[k] && wq[k].size() > 0) void'(wq[k].pop_front());
    hs = '0;
    if (rand_ready) resp_ready = ($urandom_range(0, 2) != 0);
    drive();
    @(negedge clk);
    obs_valid = resp_valid; obs_busy = busy; obs_ready = ready;
    obs_id = resp_id; obs_crc = resp_crc;
    for (int k = 0; k < N; k++) if (ready[k]) rdy_cnt[k]++;
  endtask

  task automatic push_drv(input int k, input logic [15:0] w, input logic l);
    wq[k].push_back({l, w});
  endtask

  task automatic push_mdl(input int k, input logic [15:0] w, input logic l);
    mw[k].push_back(w);
    cur_len[k]++;
    if (l) begin mlen[k].push_back(cur_len[k]); cur_len[k] = 0; end
  endtask

  task automatic push_word(input int k, input logic [15:0] w, input logic l);
    push_drv(k, w, l);
    push_mdl(k, w, l);
  endtask

  // Next expected response: first requester with a pending packet from rr_m.
  task automatic model_next(output int id, output logic [15:0] crc);
    logic [15:0] c;
    int n, k;
    id = -1; crc = '0;
    for (int i = 0; i < N; i++) begin
      k = (rr_m + i) % N;
      if (id < 0 && mlen[k].size() > 0) id = k;
    end
    if (id >= 0) begin
      c = init_v[id];
      n = mlen[id].pop_front();
      repeat (n) c = ref_crc(c, mw[id].pop_front());
      crc  = c ^ xorv_v[id];
      rr_m = (id + 1) % N;
    end
  endtask

  task automatic wait_resp(input int n, input int budget, output bit ok);
    int c = 0;
    while (rq.size() < n && c < budget) begin step(); c++; end
    ok = (rq.size() >= n);
  endtask

  task automatic clear_all();
    for (int k = 0; k < N; k++) begin
      wq[k].delete(); mw[k].delete(); mlen[k].delete(); cur_len[k] = 0; rdy_cnt[k] = 0;
    end
    rq.delete(); hs = '0; rr_m = 0;
  endtask

  task automatic apply_reset();
    rst = 1'b1;
    clear_all();
    drive();
    step(); step();
    rst = 1'b0;
    step();
  endtask

  task automatic test_reset();
    rst = 1'b1; en = 1'b1; resp_ready = 1'b1; rand_ready = 1'b0;
    for (int k = 0; k < N; k++) begin init_v[k] = '0; xorv_v[k] = '0; end
    clear_all();
    drive();
    @(negedge clk); @(negedge clk);
    vectors++;
    if ({busy, resp_valid} !== 2'b00) begin
      miscompares++; $display("FAIL reset_status: got busy/valid=%b required 00", {busy, resp_valid});
    end
    vectors++;
    if (ready !== '0) begin
      miscompares++; $display("FAIL reset_ready: got %b required 0000", ready);
    end
    vectors++;
    if ({resp_id, resp_crc} !== 18'h0) begin
      miscompares++; $display("FAIL reset_resp: got id=%0d crc=%h required 0/0000", resp_id, resp_crc);
    end
    rst = 1'b0;
    step();
    vectors++;
    if (obs_busy !== 1'b0) begin
      miscompares++; $display("FAIL reset_idle: got busy=%b required 0", obs_busy);
    end
  endtask

  task automatic run_single(input string nm, input logic [15:0] w, input logic [15:0] exp_crc);
    bit ok;
    int eid;
    logic [15:0] ecrc;
    resp_t r;
    push_word(0, w, 1'b1);
    drive();
    wait_resp(1, 30, ok);
    vectors++;
    if (!ok) begin
      miscompares++; $display("FAIL %s_timeout: got 0 responses required 1", nm);
    end else begin
      r = rq.pop_front();
      model_next(eid, ecrc);
      vectors++;
      if (r.crc !== exp_crc || r.id !== 0) begin
        miscompares++;
        $display("FAIL %s: got id=%0d crc=%h required id=0 crc=%h", nm, r.id, r.crc, exp_crc);
      end
    end
    step();
  endtask

  task automatic test_single();
    int lat = 0;
    bit ok;
    resp_t r;
    int eid;
    logic [15:0] ecrc;
    init_v[0] = 16'h0000; xorv_v[0] = 16'h0000;
    push_word(0, 16'h0001, 1'b1);
    drive();
    while (!obs_valid && lat < 30) begin step(); lat++; end
    vectors++;
    if (lat !== 6) begin
      miscompares++; $display("FAIL single_latency: got %0d cycles required 6", lat);
    end
    wait_resp(1, 10, ok);
    vectors++;
    if (!ok) begin
      miscompares++; $display("FAIL single_timeout: got 0 responses required 1");
    end else begin
      r = rq.pop_front();
      model_next(eid, ecrc);
      vectors++;
      if (r.crc !== 16'h1021 || r.id !== 0) begin
        miscompares++; $display("FAIL single_0001: got id=%0d crc=%h required id=0 crc=1021", r.id, r.crc);
      end
    end
    step();
    xorv_v[0] = 16'hFFFF;
    run_single("single_xorv", 16'h0001, 16'hEFDE);
    xorv_v[0] = 16'h0000;
    run_single("single_0002", 16'h0002, 16'h2042);
  endtask

  task automatic test_two_word();
    bit ok;
    resp_t r;
    int eid, other;
    logic [15:0] ecrc;
    for (int k = 0; k < N; k++) rdy_cnt[k] = 0;
    push_word(0, 16'h0000, 1'b0);
    push_word(0, 16'h0001, 1'b1);
    drive();
    wait_resp(1, 40, ok);
    step(); step();
    vectors++;
    if (!ok) begin
      miscompares++; $display("FAIL two_word_timeout: got 0 responses required 1");
    end else begin
      r = rq.pop_front();
      model_next(eid, ecrc);
      vectors++;
      if (r.crc !== 16'h1021) begin
        miscompares++; $display("FAIL two_word_crc: got %h required 1021", r.crc);
      end
    end
    vectors++;
    if (rdy_cnt[0] !== 2) begin
      miscompares++; $display("FAIL two_word_ready0: got %0d pulses required 2", rdy_cnt[0]);
    end
    other = rdy_cnt[1] + rdy_cnt[2] + rdy_cnt[3];
    vectors++;
    if (other !== 0) begin
      miscompares++; $display("FAIL two_word_other_ready: got %0d cycles required 0", other);
    end
  endtask

  task automatic test_rr_order();
    int order [5] = '{0, 1, 2, 3, 0};
    int c = 0, eid;
    bit ok;
    logic [1:0] h_id;
    logic [15:0] h_crc, ecrc;
    resp_t r;
    apply_reset();
    for (int k = 0; k < N; k++) begin
      init_v[k] = 16'($urandom); xorv_v[k] = 16'($urandom);
    end
    push_word(0, 16'($urandom), 1'b1);
    push_word(0, 16'($urandom), 1'b1);
    for (int k = 1; k < N; k++) push_word(k, 16'($urandom), 1'b1);
    resp_ready = 1'b0;
    drive();
    while (!obs_valid && c < 30) begin step(); c++; end
    h_id = obs_id; h_crc = obs_crc;
    for (int i = 0; i < 3; i++) begin
      step();
      vectors++;
      if (obs_valid !== 1'b1 || obs_id !== h_id || obs_crc !== h_crc || obs_ready !== '0 || obs_busy !== 1'b1) begin
        miscompares++;
        $display("FAIL rr_hold: got valid=%b id=%0d crc=%h ready=%b required valid=1 id=%0d crc=%h ready=0000",
                 obs_valid, obs_id, obs_crc, obs_ready, h_id, h_crc);
      end
    end
    resp_ready = 1'b1;
    wait_resp(5, 200, ok);
    vectors++;
    if (!ok) begin
      miscompares++; $display("FAIL rr_timeout: got %0d responses required 5", rq.size());
    end
    for (int i = 0; i < 5 && rq.size() > 0; i++) begin
      r = rq.pop_front();
      model_next(eid, ecrc);
      vectors++;
      if (r.id !== order[i] || r.crc !== ecrc) begin
        miscompares++;
        $display("FAIL rr_order[%0d]: got id=%0d crc=%h required id=%0d crc=%h", i, r.id, r.crc, order[i], ecrc);
      end
    end
  endtask

  task automatic test_en_midpacket();
    bit ok;
    resp_t r;
    int eid;
    logic [15:0] ecrc, w1;
    apply_reset();
    en = 1'b1; resp_ready = 1'b1;
    push_word(2, 16'($urandom), 1'b1);
    drive();
    step(); step(); step();
    w1 = 16'($urandom);
    push_drv(1, w1, 1'b1);
    en = 1'b0;
    drive();
    wait_resp(1, 30, ok);
    vectors++;
    if (!ok) begin
      miscompares++; $display("FAIL en_mid_timeout: got 0 responses required 1");
    end else begin
      r = rq.pop_front();
      model_next(eid, ecrc);
      vectors++;
      if (r.id !== 2 || r.crc !== ecrc) begin
        miscompares++; $display("FAIL en_mid_pkt2: got id=%0d crc=%h required id=2 crc=%h", r.id, r.crc, ecrc);
      end
    end
    for (int i = 0; i < 8; i++) begin
      step();
      vectors++;
      if (obs_busy !== 1'b0 || obs_ready !== '0 || obs_valid !== 1'b0) begin
        miscompares++;
        $display("FAIL en_off_idle: got busy=%b ready=%b valid=%b required 0/0000/0", obs_busy, obs_ready, obs_valid);
      end
    end
    push_mdl(1, w1, 1'b1);
    en = 1'b1;
    wait_resp(1, 30, ok);
    vectors++;
    if (!ok) begin
      miscompares++; $display("FAIL en_on_timeout: got 0 responses required 1");
    end else begin
      r = rq.pop_front();
      model_next(eid, ecrc);
      vectors++;
      if (r.id !== 1 || r.crc !== ecrc) begin
        miscompares++; $display("FAIL en_on_pkt1: got id=%0d crc=%h required id=1 crc=%h", r.id, r.crc, ecrc);
      end
    end
  endtask

  task automatic test_reset_midpacket();
    bit ok;
    resp_t r;
    int eid;
    logic [15:0] ecrc;
    // Move rr away from 0 first so the post-reset grant proves rr was cleared.
    push_word(1, 16'($urandom), 1'b1);
    drive();
    wait_resp(1, 30, ok);
    rq.delete(); model_next(eid, ecrc);
    step();
    for (int i = 0; i < 3; i++) push_word(3, 16'($urandom), i == 2);
    push_word(0, 16'($urandom), 1'b1);
    push_word(0, 16'($urandom), 1'b1);
    wq[0].delete();
    drive();
    step(); step(); step(); step();
    rst = 1'b1;
    clear_all();
    drive();
    step();
    vectors++;
    if (obs_busy !== 1'b0 || obs_valid !== 1'b0 || obs_ready !== '0) begin
      miscompares++;
      $display("FAIL rst_mid: got busy=%b valid=%b ready=%b required 0/0/0000", obs_busy, obs_valid, obs_ready);
    end
    rst = 1'b0;
    step();
    push_word(3, 16'($urandom), 1'b1);
    push_word(0, 16'($urandom), 1'b1);
    drive();
    wait_resp(2, 60, ok);
    vectors++;
    if (!ok) begin
      miscompares++; $display("FAIL rst_mid_timeout: got %0d responses required 2", rq.size());
    end else begin
      r = rq.pop_front();
      model_next(eid, ecrc);
      vectors++;
      if (r.id !== 0 || r.crc !== ecrc) begin
        miscompares++; $display("FAIL rst_first_grant: got id=%0d crc=%h required id=0 crc=%h", r.id, r.crc, ecrc);
      end
      r = rq.pop_front();
      model_next(eid, ecrc);
      vectors++;
      if (r.id !== 3 || r.crc !== ecrc) begin
        miscompares++; $display("FAIL rst_second_grant: got id=%0d crc=%h required id=3 crc=%h", r.id, r.crc, ecrc);
      end
    end
  endtask

  task automatic test_random();
    localparam int NPKT = 24;
    bit ok;
    resp_t r;
    int eid, k, len;
    logic [15:0] ecrc;
    apply_reset();
    for (int i = 0; i < N; i++) begin
      init_v[i] = 16'($urandom); xorv_v[i] = 16'($urandom);
    end
    for (int p = 0; p < NPKT; p++) begin
      k   = $urandom_range(0, N-1);
      len = $urandom_range(1, 4);
      for (int j = 0; j < len; j++) push_word(k, 16'($urandom), j == len-1);
    end
    rand_ready = 1'b1;
    drive();
    wait_resp(NPKT, 4000, ok);
    rand_ready = 1'b0; resp_ready = 1'b1;
    vectors++;
    if (!ok) begin
      miscompares++; $display("FAIL random_timeout: got %0d responses required %0d", rq.size(), NPKT);
    end
    while (rq.size() > 0) begin
      r = rq.pop_front();
      model_next(eid, ecrc);
      vectors++;
      if (r.id !== eid || r.crc !== ecrc) begin
        miscompares++; $display("FAIL random_pkt: got id=%0d crc=%h required id=%0d crc=%h", r.id, r.crc, eid, ecrc);
      end
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_single();
    test_two_word();
    test_rr_order();
    test_en_midpacket();
    test_reset_midpacket();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
